sync_fifo_flex: RTL and testbench

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/sync_fifo_flex.sv | 115 +++++++++++
 tb/tb_sync_fifo_flex.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with any depth, sticky overflow/underflow flags, flush,
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    parameter int FWFT       = 0
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] memQ [DEPTH];
    logic [PW-1:0]         wrPtrQ, wrPtrD;
    logic [PW-1:0]         rdPtrQ, rdPtrD;
    logic [CW-1:0]         countQ, countD;
    logic                  overflowQ, overflowD;
    logic                  underflowQ, underflowD;
    logic                  popOk;
    logic                  pushOk;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full_o         = (countQ == DEPTH_C);
    assign empty_o        = (countQ == '0);
    assign almost_full_o  = (countQ >= AFULL_C);
    assign almost_empty_o = (countQ <= AEMPTY_C);
    assign count_o        = countQ;
    assign overflow_o     = overflowQ;
    assign underflow_o    = underflowQ;

    assign popOk  = pop_i && !empty_o;
    assign pushOk = push_i && (!full_o || popOk);

    always_comb begin
        wrPtrD     = wrPtrQ;
        rdPtrD     = rdPtrQ;
        countD     = countQ;
        overflowD  = overflowQ;
        underflowD = underflowQ;
        if (flush_i) begin
            wrPtrD     = '0;
            rdPtrD     = '0;
            countD     = '0;
            overflowD  = 1'b0;
            underflowD = 1'b0;
        end else begin
            if (pushOk) wrPtrD = nextPtr(wrPtrQ);
            if (popOk)  rdPtrD = nextPtr(rdPtrQ);
            if (pushOk && !popOk)      countD = countQ + CW'(1);
            else if (popOk && !pushOk) countD = countQ - CW'(1);
            if (push_i && full_o && !pop_i) overflowD  = 1'b1;
            if (pop_i && empty_o)           underflowD = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            overflowQ  <= overflowD;
            underflowQ <= underflowD;
        end
    end

    // Storage is never cleared; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (pushOk && !flush_i) memQ[wrPtrQ] <= data_i;
    end

    generate
        if (FWFT == 0) begin : g_regRead
            logic [DATA_WIDTH-1:0] dataQ;
            always_ff @(posedge clk_i or negedge arstn_i) begin
                if (!arstn_i)     dataQ <= '0;
                else if (flush_i) dataQ <= '0;
                else if (popOk)   dataQ <= memQ[rdPtrQ];
            end
            assign data_o = dataQ;
        end else begin : g_fwft
            assign data_o = empty_o ? '0 : memQ[rdPtrQ];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: two FIFO instances (depth 4 registered-read, depth 3
// fall-through) share stimulus and are compared against a queue-based model.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data = 8'h00;

    logic [7:0] dataA, dataB;
    logic       fullA, emptyA, afullA, aemptyA, ovfA, udfA;
    logic       fullB, emptyB, afullB, aemptyB, ovfB, udfB;
    logic [2:0] countA;
    logic [1:0] countB;

    int testsRun = 0;
    int failCount = 0;

    logic [7:0] mq [2][$];
    bit         mOvf [2];
    bit         mUdf [2];
    logic [7:0] mReg [2];
    int         depthP [2] = '{4, 3};
    int         fwftP  [2] = '{0, 1};
    int         aflP   [2] = '{3, 2};
    int         aelP   [2] = '{1, 1};

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(0)) dutA (
        .clk_i(clk), .arstn_i(arstn), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .data_o(dataA), .full_o(fullA), .empty_o(emptyA),
        .almost_full_o(afullA), .almost_empty_o(aemptyA), .count_o(countA),
        .overflow_o(ovfA), .underflow_o(udfA));

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(3), .FWFT(1)) dutB (
        .clk_i(clk), .arstn_i(arstn), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .data_o(dataB), .full_o(fullB), .empty_o(emptyB),
        .almost_full_o(afullB), .almost_empty_o(aemptyB), .count_o(countB),
        .overflow_o(ovfB), .underflow_o(udfB));

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expData(input int k);
        if (fwftP[k] != 0) return (mq[k].size() > 0) ? mq[k][0] : 8'h00;
        return mReg[k];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mOvf[k] = 1'b0;
            mUdf[k] = 1'b0;
            mReg[k] = 8'h00;
        end
    endtask

    // One clock edge of the behavioural FIFO, using the inputs held across it.
    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            int sz = mq[k].size();
            bit popOk;
            bit pushOk;
            logic [7:0] head;
            if (flush) begin
                mq[k].delete();
                mOvf[k] = 1'b0;
                mUdf[k] = 1'b0;
                mReg[k] = 8'h00;
            end else begin
                popOk  = pop && (sz > 0);
                pushOk = push && ((sz < depthP[k]) || popOk);
                if (push && (sz == depthP[k]) && !pop) mOvf[k] = 1'b1;
                if (pop && (sz == 0)) mUdf[k] = 1'b1;
                if (popOk) begin
                    head = mq[k].pop_front();
                    if (fwftP[k] == 0) mReg[k] = head;
                end
                if (pushOk) mq[k].push_back(data);
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("A.data",   32'(dataA),   32'(expData(0)));
        checkOutput("A.count",  32'(countA),  32'(mq[0].size()));
        checkOutput("A.full",   32'(fullA),   32'(mq[0].size() == depthP[0]));
        checkOutput("A.empty",  32'(emptyA),  32'(mq[0].size() == 0));
        checkOutput("A.afull",  32'(afullA),  32'(mq[0].size() >= aflP[0]));
        checkOutput("A.aempty", 32'(aemptyA), 32'(mq[0].size() <= aelP[0]));
        checkOutput("A.ovf",    32'(ovfA),    32'(mOvf[0]));
        checkOutput("A.udf",    32'(udfA),    32'(mUdf[0]));
        checkOutput("B.data",   32'(dataB),   32'(expData(1)));
        checkOutput("B.count",  32'(countB),  32'(mq[1].size()));
        checkOutput("B.full",   32'(fullB),   32'(mq[1].size() == depthP[1]));
        checkOutput("B.empty",  32'(emptyB),  32'(mq[1].size() == 0));
        checkOutput("B.afull",  32'(afullB),  32'(mq[1].size() >= aflP[1]));
        checkOutput("B.aempty", 32'(aemptyB), 32'(mq[1].size() <= aelP[1]));
        checkOutput("B.ovf",    32'(ovfB),    32'(mOvf[1]));
        checkOutput("B.udf",    32'(udfB),    32'(mUdf[1]));
    endtask

    task automatic applyStimulus(input bit pu, input bit po, input logic [7:0] d, input bit fl);
        push  = pu;
        pop   = po;
        data  = d;
        flush = fl;
        @(posedge clk);
        #1;
        modelEdge();
        checkAll();
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("rst.emptyA", 32'(emptyA), 32'd1);
        arstn = 1'b1;

        // Fill depth-4 FIFO, then overflow it.
        applyStimulus(1, 0, 8'h11, 0);
        applyStimulus(1, 0, 8'h22, 0);
        applyStimulus(1, 0, 8'h33, 0);
        applyStimulus(1, 0, 8'h44, 0);
        checkOutput("fill.fullA", 32'(fullA), 32'd1);
        checkOutput("fill.countA", 32'(countA), 32'd4);
        applyStimulus(1, 0, 8'h55, 0);
        checkOutput("ovf.flagA", 32'(ovfA), 32'd1);
        checkOutput("ovf.countA", 32'(countA), 32'd4);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop1.dataA", 32'(dataA), 32'h11);
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop4.dataA", 32'(dataA), 32'h44);
        applyStimulus(0, 0, 8'h00, 1);

        // Steady push/pop at occupancy one wraps the pointers repeatedly.
        applyStimulus(1, 0, 8'd1, 0);
        for (int i = 2; i <= 11; i++) begin
            applyStimulus(1, 1, 8'(i), 0);
            checkOutput("wrap.countA", 32'(countA), 32'd1);
            checkOutput("wrap.countB", 32'(countB), 32'd1);
            checkOutput("wrap.dataA", 32'(dataA), 32'(i - 1));
        end
        applyStimulus(0, 0, 8'h00, 1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'(8'hA0 + i), 0);
        applyStimulus(1, 1, 8'hAA, 0);
        checkOutput("fullpp.fullA", 32'(fullA), 32'd1);
        checkOutput("fullpp.ovfA", 32'(ovfA), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 0);
        checkOutput("fullpp.lastA", 32'(dataA), 32'hAA);
        applyStimulus(0, 0, 8'h00, 1);

        // Underflow, push+pop on empty, then flush clears sticky flags.
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("udf.flagA", 32'(udfA), 32'd1);
        applyStimulus(1, 1, 8'h5A, 0);
        checkOutput("emptypp.countA", 32'(countA), 32'd1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("flush.udfA", 32'(udfA), 32'd0);
        checkOutput("flush.emptyA", 32'(emptyA), 32'd1);

        // Fall-through output on the depth-3 instance.
        applyStimulus(1, 0, 8'h77, 0);
        checkOutput("fwft.dataB", 32'(dataB), 32'h77);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("fwft.emptyB", 32'(emptyB), 32'd1);
        checkOutput("fwft.dataB0", 32'(dataB), 32'h00);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), ($urandom_range(0, 31) == 0));
        end
        applyStimulus(0, 0, 8'h00, 1);

        // Almost thresholds while filling, then async reset mid-fill.
        applyStimulus(1, 0, 8'h01, 0);
        checkOutput("thr1.aemptyA", 32'(aemptyA), 32'd1);
        applyStimulus(1, 0, 8'h02, 0);
        checkOutput("thr2.aemptyA", 32'(aemptyA), 32'd0);
        checkOutput("thr2.afullA", 32'(afullA), 32'd0);
        applyStimulus(1, 0, 8'h03, 0);
        checkOutput("thr3.afullA", 32'(afullA), 32'd1);
        #2;
        arstn = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("arst.countA", 32'(countA), 32'd0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        applyStimulus(1, 0, 8'h3C, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("postrst.dataA", 32'(dataA), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
